riscv_dmem_ctrl: RTL and testbench



---
 rtl/riscv_dmem_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_riscv_dmem_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_ctrl.sv
// Data-memory controller for the load/store path: one request in flight, configurable
// wait states, byte/halfword/word access with extension, lane writes and fault flagging.
module riscv_dmem_ctrl #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);

  localparam int unsigned IdxW    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CntLast = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            accept, enter_resp;

  logic            we_q, uns_q;
  logic [1:0]      size_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [XLEN-1:0] resp_rdata_q;
  logic            resp_err_q;

  // With zero wait states the commit edge is the accept edge, so the live inputs are used there.
  logic            cur_we, cur_uns;
  logic [1:0]      cur_size;
  logic [XLEN-1:0] cur_addr, cur_wdata;
  logic [IdxW-1:0] cur_idx;

  logic            err;
  logic [3:0]      be;
  logic [XLEN-1:0] wlanes, rd_word, rd_shift, load_val;

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // Select the request fields seen on the commit edge.
  always_comb begin
    cur_we    = we_q;
    cur_uns   = uns_q;
    cur_size  = size_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state_q == StIdle) begin
      cur_we    = req_we;
      cur_uns   = req_unsigned;
      cur_size  = req_size;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end
    cur_idx = cur_addr[IdxW+1:2];
  end

  // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept = 1'b1;
          cnt_d  = '0;
          if (WAIT_STATES == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == CntLast) begin
          state_d    = StResp;
          enter_resp = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Fault detection: misalignment, reserved size, or word index beyond the array.
  always_comb begin
    err = 1'b0;
    case (cur_size)
      2'b01:   err = cur_addr[0];
      2'b10:   err = (cur_addr[1:0] != 2'b00);
      2'b11:   err = 1'b1;
      default: err = 1'b0;
    endcase
    if ({2'b00, cur_addr[XLEN-1:2]} >= XLEN'(DEPTH_WORDS)) err = 1'b1;
  end

  // Store lane enables with the right-aligned data replicated across lanes.
  always_comb begin
    be     = 4'b1111;
    wlanes = cur_wdata;
    case (cur_size)
      2'b00: begin
        be     = 4'b0001 << cur_addr[1:0];
        wlanes = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be     = cur_addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{cur_wdata[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  // Load extraction from the addressed lanes with sign or zero extension.
  always_comb begin
    rd_word  = mem[cur_idx];
    rd_shift = rd_word >> {cur_addr[1:0], 3'b000};
    case (cur_size)
      2'b00: load_val = cur_uns ? {{(XLEN-8){1'b0}}, rd_shift[7:0]}
                                : {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
      2'b01: load_val = cur_uns ? {{(XLEN-16){1'b0}}, rd_shift[15:0]}
                                : {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
      default: load_val = rd_word;
    endcase
  end

  // State, captured request, response registers and the RAM write on the edge entering RESP.
  // RAM words are never reset; keeping the write in the reset-else branch blocks commits
  // while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (enter_resp) begin
        resp_err_q   <= err;
        resp_rdata_q <= (err || cur_we) ? '0 : load_val;
        if (cur_we && !err) begin
          for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[cur_idx][8*i +: 8] <= wlanes[8*i +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Randomised bench for riscv_dmem_ctrl with a byte-array reference model and directed pins.
module tb_riscv_dmem_ctrl;

  localparam int WS_A  = 2;
  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst_a, va, rdy, we, un, rv, er;
  logic [1:0]  sz;
  logic [31:0] ad, wd, rd;
  logic        rst_b, vb, rdyb, web, unb, rvb, erb;
  logic [1:0]  szb;
  logic [31:0] adb, wdb, rdb;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  riscv_dmem_ctrl #(.XLEN(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_A)) dut_a (
    .clk(clk), .reset(rst_a), .req_valid(va), .req_ready(rdy), .req_we(we), .req_size(sz),
    .req_unsigned(un), .req_addr(ad), .req_wdata(wd), .resp_valid(rv), .resp_rdata(rd),
    .resp_err(er)
  );

  riscv_dmem_ctrl #(.XLEN(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut_b (
    .clk(clk), .reset(rst_b), .req_valid(vb), .req_ready(rdyb), .req_we(web), .req_size(szb),
    .req_unsigned(unb), .req_addr(adb), .req_wdata(wdb), .resp_valid(rvb), .resp_rdata(rdb),
    .resp_err(erb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] ad;
    logic [31:0] wd;
    int          due;
  } req_t;

  req_t        q[$];
  req_t        m_cur;
  logic        m_err;
  logic [31:0] m_rd;
  logic [7:0]  mbyte [4096];

  function automatic logic exp_err(input logic [1:0] s, input logic [31:0] a);
    int unsigned nbytes;
    if (s == 2'd3) return 1'b1;
    nbytes = 1 << s;
    if ((a % nbytes) != 0) return 1'b1;
    return (a / 4) >= DEPTH;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] s, input logic u,
                                            input logic [31:0] a);
    int     n;
    longint v;
    n = 1 << s;
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(mbyte[int'(a[11:0]) + i]) << (8 * i);
    if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  // Single compare process for dut_a: ready, response timing, data and error every cycle.
  always @(negedge clk) begin
    if (!rst_a) begin
      q.delete();
      chk("reset_ready", 32'(rdy), 32'd1);
      chk("reset_resp_valid", 32'(rv), 32'd0);
      chk("reset_rdata", rd, 32'd0);
      chk("reset_err", 32'(er), 32'd0);
    end else begin
      chk("ready", 32'(rdy), 32'(q.size() == 0));
      if (rv) begin
        if (q.size() == 0) begin
          chk("spurious_resp", 32'(rv), 32'd0);
        end else begin
          m_cur = q.pop_front();
          m_err = exp_err(m_cur.sz, m_cur.ad);
          m_rd  = (m_err || m_cur.we) ? 32'd0 : exp_load(m_cur.sz, m_cur.un, m_cur.ad);
          chk("resp_cycle", 32'(cyc), 32'(m_cur.due));
          chk("resp_rdata", rd, m_rd);
          chk("resp_err", 32'(er), 32'(m_err));
          if (!m_err && m_cur.we) begin
            for (int i = 0; i < (1 << m_cur.sz); i++)
              mbyte[int'(m_cur.ad[11:0]) + i] = m_cur.wd[8*i +: 8];
          end
        end
      end else if (q.size() != 0 && cyc >= q[0].due) begin
        chk("resp_missing", 32'(rv), 32'd1);
        void'(q.pop_front());
      end
      if (va && rdy) begin
        m_cur.we  = we;
        m_cur.sz  = sz;
        m_cur.un  = un;
        m_cur.ad  = ad;
        m_cur.wd  = wd;
        m_cur.due = cyc + 1 + WS_A;
        q.push_back(m_cur);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic scramble();
    we = 1'($urandom_range(0, 1));
    sz = 2'($urandom_range(0, 3));
    un = 1'($urandom_range(0, 1));
    ad = $urandom;
    wd = $urandom;
  endtask

  task automatic xfer(input logic w, input logic [1:0] s, input logic u, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] r, output logic e,
                      output int lat);
    int n;
    @(posedge clk); #1;
    va = 1'b1; we = w; sz = s; un = u; ad = a; wd = d;
    n = 0;
    @(negedge clk);
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    r = 32'd0; e = 1'b0; lat = -1;
    if (!rdy) begin
      chk("accept_timeout", 32'(rdy), 32'd1);
      va = 1'b0;
      return;
    end
    @(posedge clk); #1;
    va = 1'b0;
    scramble();
    @(negedge clk);
    lat = 1;
    while (!rv && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!rv) chk("resp_timeout", 32'(rv), 32'd1);
    r = rd;
    e = er;
  endtask

  logic [31:0] r;
  logic        e;
  int          lat;
  int          acc;
  logic [31:0] ra;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; va = 1'b0; vb = 1'b0;
    we = 1'b0; sz = 2'd0; un = 1'b0; ad = '0; wd = '0;
    web = 1'b0; szb = 2'd0; unb = 1'b0; adb = '0; wdb = '0;
    for (int i = 0; i < 4096; i++) mbyte[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Give every byte the random phase can touch a known value.
    for (int i = 0; i < 16; i++) xfer(1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom, r, e, lat);
    for (int i = 0; i < 4; i++) xfer(1'b1, 2'd2, 1'b0, 32'h0FF0 + 32'(4 * i), $urandom, r, e, lat);

    // Word store / load and latency.
    xfer(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, r, e, lat);
    chk("st_word_lat", 32'(lat), 32'd3);
    chk("st_word_err", 32'(e), 32'd0);
    chk("st_word_rdata", r, 32'd0);
    xfer(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, r, e, lat);
    chk("ld_word_lat", 32'(lat), 32'd3);
    chk("ld_word", r, 32'hDEADBEEF);

    // Byte lane store, byte loads with both extensions.
    xfer(1'b1, 2'd0, 1'b0, 32'h12, 32'hFFFFFF5A, r, e, lat);
    xfer(1'b0, 2'd2, 1'b1, 32'h10, 32'h0, r, e, lat);
    chk("ld_after_byte_st", r, 32'hDE5ABEEF);
    xfer(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, r, e, lat);
    chk("ld_byte_signed", r, 32'hFFFFFFDE);
    xfer(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, r, e, lat);
    chk("ld_byte_unsigned", r, 32'h000000DE);

    // Halfword store into the upper lanes.
    xfer(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, r, e, lat);
    xfer(1'b1, 2'd1, 1'b0, 32'h22, 32'hABCD8001, r, e, lat);
    xfer(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, r, e, lat);
    chk("ld_half_signed", r, 32'hFFFF8001);
    xfer(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, r, e, lat);
    chk("ld_half_unsigned", r, 32'h00008001);
    xfer(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, r, e, lat);
    chk("half_lanes_kept", r, 32'h80013344);

    // Faults: misaligned and reserved size leave memory untouched.
    xfer(1'b1, 2'd2, 1'b0, 32'h14, 32'hA5A5A5A5, r, e, lat);
    xfer(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, r, e, lat);
    chk("mis_word_err", 32'(e), 32'd1);
    chk("mis_word_rdata", r, 32'd0);
    xfer(1'b1, 2'd1, 1'b0, 32'h15, 32'h0000FFFF, r, e, lat);
    chk("mis_half_st_err", 32'(e), 32'd1);
    xfer(1'b1, 2'd3, 1'b0, 32'h14, 32'h00000000, r, e, lat);
    chk("size11_err", 32'(e), 32'd1);
    xfer(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, r, e, lat);
    chk("fault_no_write", r, 32'hA5A5A5A5);
    chk("fault_no_write_err", 32'(e), 32'd0);

    // Range boundary.
    xfer(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, r, e, lat);
    chk("range_over_err", 32'(e), 32'd1);
    chk("range_over_rdata", r, 32'd0);
    xfer(1'b0, 2'd2, 1'b0, 32'h0FFC, 32'h0, r, e, lat);
    chk("range_top_err", 32'(e), 32'd0);

    // Reset during WAIT of a store discards it.
    xfer(1'b1, 2'd2, 1'b0, 32'h0, 32'h0, r, e, lat);
    @(posedge clk); #1;
    va = 1'b1; we = 1'b1; sz = 2'd2; un = 1'b0; ad = 32'h0; wd = 32'h12345678;
    @(negedge clk);
    chk("pre_reset_ready", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    va = 1'b0;
    #2 rst_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    rst_a = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(rdy), 32'd1);
    chk("no_resp_after_reset", 32'(rv), 32'd0);
    xfer(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, r, e, lat);
    chk("reset_discard_store", r, 32'h0);

    // Randomised traffic; the compare process checks each response.
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 9))
        0:       ra = 32'h1000 + 32'($urandom_range(0, 255));
        1:       ra = $urandom;
        2, 3:    ra = 32'h0FF0 + 32'($urandom_range(0, 15));
        default: ra = 32'($urandom_range(0, 63));
      endcase
      xfer(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra,
           $urandom, r, e, lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Zero wait states: req_valid held high is accepted every second cycle.
    @(posedge clk); #1;
    vb = 1'b1; web = 1'b1; szb = 2'd2; unb = 1'b0; adb = 32'h8; wdb = 32'hCAFEF00D;
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("b2b_ready", 32'(rdyb), 32'((k % 2) == 0));
      chk("b2b_resp_valid", 32'(rvb), 32'((k % 2) == 1));
      if (rdyb) acc++;
    end
    chk("b2b_accepts", 32'(acc), 32'd6);
    @(posedge clk); #1;
    vb = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    vb = 1'b1; web = 1'b0;
    @(negedge clk);
    chk("ws0_ready", 32'(rdyb), 32'd1);
    @(posedge clk); #1;
    vb = 1'b0;
    @(negedge clk);
    chk("ws0_resp_valid", 32'(rvb), 32'd1);
    chk("ws0_rdata", rdb, 32'hCAFEF00D);
    chk("ws0_err", 32'(erb), 32'd0);

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
